// File: rtl/cmp_pkg.sv
// Shared definitions for the compare-accelerator bitmap loader: frame
// geometry, word-counter width and the loader state encoding.
package cmp_pkg;

  localparam int WORD_W   = 16;
  localparam int BITMAP_W = 1536;
  localparam int NWORDS   = BITMAP_W / WORD_W;
  localparam int CNT_W    = 7;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_word_ctr.sv
// Word position counter for the bitmap loader. Clear wins over increment;
// is_last flags the final word slot of a frame.
module cmp_word_ctr
  import cmp_pkg::*;
#(
  parameter int FRAME_WORDS = NWORDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             is_last
);

  logic [CNT_W-1:0] cnt_r;

  // Word index register: cleared on frame boundaries, advanced per stored word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt     = cnt_r;
  assign is_last = (cnt_r == CNT_W'(FRAME_WORDS - 1));

endmodule

// File: rtl/cmp_bitmap_loader.sv
// Packs a stream of bus words into one wide note bitmap, fires a single
// start pulse to the compare ALU, holds the bitmap until the ALU's done
// edge, then re-arms. Malformed frames raise a one-cycle load_err.
module cmp_bitmap_loader #(
  parameter int WORD_W   = cmp_pkg::WORD_W,
  parameter int BITMAP_W = cmp_pkg::BITMAP_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic                wr_last,
  input  logic                abort,
  output logic [BITMAP_W-1:0] bitmap,
  output logic                start,
  input  logic                done,
  output logic                busy,
  output logic                load_err,
  output logic [7:0]          frame_cnt
);

  import cmp_pkg::*;

  localparam int NWORDS = BITMAP_W / WORD_W;
  localparam int IDX_W  = $clog2(BITMAP_W);

  state_t                state_r;
  state_t                state_s;
  logic                  done_q_r;
  logic                  start_r;
  logic                  load_err_r;
  logic [7:0]            frame_cnt_r;
  logic [BITMAP_W-1:0]   bitmap_r;

  logic [CNT_W-1:0]      cnt_s;
  logic                  is_last_s;
  logic                  xfer_s;
  logic                  done_edge_s;
  logic                  cnt_clr_s;
  logic                  cnt_inc_s;
  logic                  wr_en_s;
  logic                  bm_clr_s;
  logic                  err_s;
  logic                  frame_inc_s;
  logic [IDX_W-1:0]      wr_base_s;

  cmp_word_ctr #(
    .FRAME_WORDS (NWORDS)
  ) u_word_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr_s),
    .inc     (cnt_inc_s),
    .cnt     (cnt_s),
    .is_last (is_last_s)
  );

  // wr_ready is decoded from state and forced low while reset is asserted.
  assign wr_ready    = rst_n & (state_r == ST_LOAD);
  assign busy        = (state_r == ST_FIRE) | (state_r == ST_WAIT);
  assign xfer_s      = wr_valid & wr_ready;
  assign done_edge_s = done & ~done_q_r;
  assign wr_base_s   = IDX_W'(cnt_s) * IDX_W'(WORD_W);

  // Next-state and per-cycle control decode; abort overrides everything.
  always_comb begin
    state_s     = state_r;
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    wr_en_s     = 1'b0;
    bm_clr_s    = 1'b0;
    err_s       = 1'b0;
    frame_inc_s = 1'b0;
    if (abort) begin
      state_s   = ST_LOAD;
      cnt_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (xfer_s) begin
            if (is_last_s && wr_last) begin
              // Final word of a well-formed frame: store it and fire.
              wr_en_s   = 1'b1;
              cnt_clr_s = 1'b1;
              state_s   = ST_FIRE;
            end else if (is_last_s || wr_last) begin
              // last flag and word position disagree: drop the frame.
              err_s     = 1'b1;
              cnt_clr_s = 1'b1;
              bm_clr_s  = 1'b1;
              state_s   = ST_LOAD;
            end else begin
              wr_en_s   = 1'b1;
              cnt_inc_s = 1'b1;
              state_s   = ST_LOAD;
            end
          end else begin
            state_s = ST_LOAD;
          end
        end
        ST_FIRE: begin
          state_s = ST_WAIT;
        end
        ST_WAIT: begin
          // Only a fresh rising edge counts, so a done level left over
          // from the previous frame cannot complete this one.
          if (done_edge_s) begin
            frame_inc_s = 1'b1;
            cnt_clr_s   = 1'b1;
            state_s     = ST_LOAD;
          end else begin
            state_s = ST_WAIT;
          end
        end
        default: begin
          state_s   = ST_LOAD;
          cnt_clr_s = 1'b1;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered status outputs and the done edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q_r    <= 1'b0;
      start_r     <= 1'b0;
      load_err_r  <= 1'b0;
      frame_cnt_r <= 8'd0;
    end else begin
      done_q_r   <= done;
      start_r    <= (state_s == ST_FIRE);
      load_err_r <= err_s;
      if (frame_inc_s) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  // Bitmap storage: word n lands at bits [WORD_W*n +: WORD_W]; cleared only
  // on a framing error, otherwise held until overwritten by the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_r <= {BITMAP_W{1'b0}};
    end else if (bm_clr_s) begin
      bitmap_r <= {BITMAP_W{1'b0}};
    end else if (wr_en_s) begin
      bitmap_r[wr_base_s +: WORD_W] <= wr_data;
    end else begin
      bitmap_r <= bitmap_r;
    end
  end

  assign bitmap    = bitmap_r;
  assign start     = start_r;
  assign load_err  = load_err_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_cmp_bitmap_loader.sv
// Self-checking bench for cmp_bitmap_loader: directed framing/abort/done
// scenarios followed by 256 randomized frames, checked against a frame-level
// reference (word list per frame, frame counter, start pulse count).
module tb_cmp_bitmap_loader;

  localparam int WW = 16;
  localparam int BW = 1536;
  localparam int NW = 96;

  logic          clk;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [WW-1:0] wr_data;
  logic          wr_last;
  logic          abort;
  logic [BW-1:0] bitmap;
  logic          start;
  logic          done;
  logic          busy;
  logic          load_err;
  logic [7:0]    frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int fc       = 0;

  cmp_bitmap_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .abort     (abort),
    .bitmap    (bitmap),
    .start     (start),
    .done      (done),
    .busy      (busy),
    .load_err  (load_err),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count start pulses away from the active edge.
  always @(negedge clk) begin
    if (start) n_start++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the bitmap with an expected word list; reports the first bad word.
  task automatic check_bitmap(input string tag, input logic [WW-1:0] w[NW]);
    int bad;
    bad = -1;
    for (int i = 0; i < NW; i++) begin
      if (bad < 0 && bitmap[WW*i +: WW] !== w[i]) bad = i;
    end
    if (bad < 0) bad = 0;
    chk($sformatf("%s[%0d]", tag, bad), 64'(bitmap[WW*bad +: WW]), 64'(w[bad]));
  endtask

  // Offer one word, with an optional random idle gap first; waits for ready.
  task automatic offer(input logic [WW-1:0] d, input logic last, input logic ab, input int gap_max);
    int g;
    int k;
    g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    wr_valid = 1'b0;
    repeat (g) tick();
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    abort    = ab;
    k = 0;
    while (!wr_ready && k < 20) begin
      tick();
      k++;
    end
    chk("wr_ready", 64'(wr_ready), 64'd1);
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    abort    = 1'b0;
  endtask

  // Send words first..95 of a frame (last on word 95) and check the fire cycle.
  task automatic send_frame(input logic [WW-1:0] w[NW], input int first, input int gap_max);
    for (int i = first; i < NW; i++) offer(w[i], (i == NW - 1), 1'b0, gap_max);
    chk("start_fire", 64'(start), 64'd1);
    chk("busy_fire", 64'(busy), 64'd1);
    chk("ready_fire", 64'(wr_ready), 64'd0);
    chk("err_fire", 64'(load_err), 64'd0);
    check_bitmap("bitmap_fire", w);
  endtask

  // From the fire cycle: wait 'delay' cycles in WAIT with junk writes offered,
  // then raise done and expect re-arm with the frame count advanced.
  task automatic finish_alu(input logic [WW-1:0] w[NW], input int delay);
    tick();
    chk("start_once", 64'(start), 64'd0);
    for (int i = 0; i < delay; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_last  = 1'($urandom_range(0, 1));
      wr_data  = 16'($urandom);
      chk("busy_wait", 64'(busy), 64'd1);
      chk("ready_wait", 64'(wr_ready), 64'd0);
      chk("err_wait", 64'(load_err), 64'd0);
      check_bitmap("bitmap_wait", w);
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    done     = 1'b1;
    tick();
    fc = (fc + 1) % 256;
    chk("ready_rearm", 64'(wr_ready), 64'd1);
    chk("busy_rearm", 64'(busy), 64'd0);
    chk("frame_cnt", 64'(frame_cnt), 64'(fc));
    check_bitmap("bitmap_rearm", w);
    done = 1'b0;
  endtask

  logic [WW-1:0] w[NW];
  logic [WW-1:0] z[NW];
  int            starts_before;

  initial begin
    for (int i = 0; i < NW; i++) z[i] = 16'd0;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 16'd0;
    wr_last  = 1'b0;
    abort    = 1'b0;
    done     = 1'b0;

    // Reset state.
    repeat (3) tick();
    chk("rst_ready", 64'(wr_ready), 64'd0);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(load_err), 64'd0);
    chk("rst_fcnt", 64'(frame_cnt), 64'd0);
    check_bitmap("rst_bitmap", z);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(wr_ready), 64'd1);

    // Frame of index words with a stale done held high across WAIT entry.
    for (int i = 0; i < NW; i++) w[i] = 16'(i);
    done = 1'b1;
    send_frame(w, 0, 0);
    chk("idx_lsb", 64'(bitmap[15:0]), 64'd0);
    chk("idx_msb", 64'(bitmap[1535:1520]), 64'd95);
    tick();
    chk("start_once_t1", 64'(start), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stale_done_busy", 64'(busy), 64'd1);
      tick();
    end
    done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("low_done_busy", 64'(busy), 64'd1);
      chk("low_done_fcnt", 64'(frame_cnt), 64'd0);
      tick();
    end
    done = 1'b1;
    tick();
    fc = 1;
    chk("rearm_ready_t2", 64'(wr_ready), 64'd1);
    chk("fcnt_t2", 64'(frame_cnt), 64'd1);
    done = 1'b0;

    // Early wr_last on word 40.
    for (int i = 0; i < NW; i++) w[i] = 16'($urandom);
    for (int i = 0; i < 39; i++) offer(w[i], 1'b0, 1'b0, 1);
    offer(w[39], 1'b1, 1'b0, 0);
    chk("early_last_err", 64'(load_err), 64'd1);
    chk("early_last_ready", 64'(wr_ready), 64'd1);
    chk("early_last_start", 64'(start), 64'd0);
    check_bitmap("early_last_clr", z);
    tick();
    chk("err_pulse_len", 64'(load_err), 64'd0);
    for (int i = 0; i < NW; i++) w[i] = 16'($urandom);
    send_frame(w, 0, 1);
    finish_alu(w, 3);

    // 96th word without wr_last.
    for (int i = 0; i < NW; i++) w[i] = 16'($urandom);
    for (int i = 0; i < NW; i++) offer(w[i], 1'b0, 1'b0, 0);
    chk("missing_last_err", 64'(load_err), 64'd1);
    chk("missing_last_start", 64'(start), 64'd0);
    chk("missing_last_busy", 64'(busy), 64'd0);
    check_bitmap("missing_last_clr", z);
    tick();
    chk("missing_last_nostart", 64'(start), 64'd0);

    // Abort on the same cycle as word 50: dropped, counter restarts at 0.
    for (int i = 0; i < NW; i++) w[i] = 16'($urandom);
    w[49] = 16'($urandom_range(1, 65535));
    for (int i = 0; i < 49; i++) offer(w[i], 1'b0, 1'b0, 0);
    offer(w[49], 1'b0, 1'b1, 0);
    chk("abort_no_err", 64'(load_err), 64'd0);
    chk("abort_ready", 64'(wr_ready), 64'd1);
    chk("abort_dropped", 64'(bitmap[WW*49 +: WW]), 64'd0);
    for (int i = 0; i < NW; i++) w[i] = 16'($urandom);
    offer(w[0], 1'b0, 1'b0, 0);
    chk("after_abort_idx0", 64'(bitmap[15:0]), 64'(w[0]));
    chk("after_abort_no_err", 64'(load_err), 64'd0);
    send_frame(w, 1, 0);

    // Abort in WAIT coinciding with a done edge.
    tick();
    tick();
    chk("wait_busy_t5", 64'(busy), 64'd1);
    done  = 1'b1;
    abort = 1'b1;
    tick();
    chk("wait_abort_ready", 64'(wr_ready), 64'd1);
    chk("wait_abort_fcnt", 64'(frame_cnt), 64'(fc));
    check_bitmap("wait_abort_keep", w);
    done  = 1'b0;
    abort = 1'b0;
    tick();

    // 256 back-to-back randomized frames: frame count must wrap.
    starts_before = n_start;
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < NW; i++) w[i] = 16'($urandom);
      send_frame(w, 0, 1);
      finish_alu(w, $urandom_range(1, 5));
    end
    chk("start_count_256", 64'(n_start - starts_before), 64'd256);
    chk("fcnt_wrapped", 64'(frame_cnt), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
